// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO drain/demux slice.
// Holds the controller state encodings, the word and threshold widths, the
// position of the destination selector field and the threshold reset values.
package fifo_pkg;

  localparam int FIFO_DATA_W = 10;
  localparam int FIFO_TH_W   = 3;
  localparam int NUM_DEST    = 4;
  localparam int CNT_W       = 8;

  // The destination selector is the top two bits of a word.
  localparam int SEL_W = 2;

  localparam logic [FIFO_TH_W-1:0] SUP_TH_DEF = 3'b110;
  localparam logic [FIFO_TH_W-1:0] INF_TH_DEF = 3'b001;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

  // One-hot push vector for a destination index.
  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [SEL_W-1:0] sel);
    dest_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/dest_counter.sv
// dest_counter: saturating event counter with synchronous clear.
// Ports:
//   clk, reset_L : clock and asynchronous active-low reset
//   clr          : zero the count (has priority over inc)
//   inc          : count one event; the count sticks at all-ones
//   count        : current count
module dest_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_drain_demux.sv
// fifo_drain_demux: consumer of the 10-bit FIFO. Pops words while the FIFO is
// non-empty, routes each word by its two MSBs to one of four destinations, and
// stalls on a destination's almost_full using a one-word hold register so that
// word order is kept across all destinations. Also owns the FIFO thresholds,
// which are loaded while in INIT.
//
// Optional feature: define DRAIN_COUNT_EN to add per-destination 8-bit
// saturating push counters on output dest_count.
//
// Ports:
//   clk, reset_L        clock, asynchronous active-low reset
//   init                request INIT (threshold load)
//   sup_th_in/inf_th_in thresholds latched while in INIT
//   fifo_data           FIFO data_out, valid the cycle after fifo_pop
//   fifo_empty          FIFO empty flag
//   dest_almost_full    almost_full of destinations 0..3
//   fifo_pop            combinational pop to the FIFO
//   sup/inf_threshold   thresholds driven to the FIFO
//   dest_push           registered one-hot push
//   dest_data           registered word for the destinations
//   state, idle         one-hot controller state, high in IDLE
//   dest_count          (DRAIN_COUNT_EN only) 4 x 8-bit counts, dest 0 in LSBs
module fifo_drain_demux
  import fifo_pkg::*;
#(
  parameter int              DATA_W  = FIFO_DATA_W,
  parameter int              TH_W    = FIFO_TH_W,
  parameter logic [TH_W-1:0] SUP_DEF = SUP_TH_DEF,
  parameter logic [TH_W-1:0] INF_DEF = INF_TH_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [TH_W-1:0]   sup_th_in,
  input  logic [TH_W-1:0]   inf_th_in,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [3:0]        dest_almost_full,
  output logic              fifo_pop,
  output logic [TH_W-1:0]   sup_threshold,
  output logic [TH_W-1:0]   inf_threshold,
  output logic [3:0]        dest_push,
  output logic [DATA_W-1:0] dest_data,
  output logic [3:0]        state,
  output logic              idle
`ifdef DRAIN_COUNT_EN
  ,
  output logic [4*CNT_W-1:0] dest_count
`endif
);

  state_e            state_q, state_d;
  logic              idle_q, idle_d;
  logic              pending_q, pending_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [3:0]        dest_push_q, dest_push_d;
  logic [DATA_W-1:0] dest_data_q, dest_data_d;
  logic [TH_W-1:0]   sup_q, sup_d;
  logic [TH_W-1:0]   inf_q, inf_d;

  logic [SEL_W-1:0]  sel_fifo;
  logic [SEL_W-1:0]  sel_hold;
  logic              fifo_stall;

  assign sel_fifo = fifo_data[DATA_W-1 -: SEL_W];
  assign sel_hold = hold_data_q[DATA_W-1 -: SEL_W];

  // The word on fifo_data is only meaningful while pending; if its destination
  // is full it moves to the hold register, so no further pop may be issued.
  assign fifo_stall = pending_q & dest_almost_full[sel_fifo];

  assign fifo_pop = (state_q == ST_ACTIVE) & ~init & ~fifo_empty &
                    ~hold_valid_q & ~fifo_stall;

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = init ? ST_INIT : ST_IDLE;
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)             state_d = ST_INIT;
        else if (!fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Only leave once nothing is in flight; init already blocks new pops.
        if (!pending_q && !hold_valid_q) begin
          if (init)            state_d = ST_INIT;
          else if (fifo_empty) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // Datapath: pending word, hold register and registered push.
  always_comb begin
    pending_d    = fifo_pop;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    dest_push_d  = '0;
    dest_data_d  = dest_data_q;
    sup_d        = sup_q;
    inf_d        = inf_q;

    // A held word blocks pops, so pending and hold_valid are never both set.
    if (hold_valid_q) begin
      if (!dest_almost_full[sel_hold]) begin
        dest_push_d  = dest_onehot(sel_hold);
        dest_data_d  = hold_data_q;
        hold_valid_d = 1'b0;
      end
    end else if (pending_q) begin
      if (dest_almost_full[sel_fifo]) begin
        hold_valid_d = 1'b1;
        hold_data_d  = fifo_data;
      end else begin
        dest_push_d = dest_onehot(sel_fifo);
        dest_data_d = fifo_data;
      end
    end

    if (state_q == ST_INIT) begin
      sup_d = sup_th_in;
      inf_d = inf_th_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_RESET;
      idle_q       <= 1'b0;
      pending_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      dest_push_q  <= '0;
      dest_data_q  <= '0;
      sup_q        <= SUP_DEF;
      inf_q        <= INF_DEF;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      pending_q    <= pending_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      dest_push_q  <= dest_push_d;
      dest_data_q  <= dest_data_d;
      sup_q        <= sup_d;
      inf_q        <= inf_d;
    end
  end

  assign state         = state_q;
  assign idle          = idle_q;
  assign dest_push     = dest_push_q;
  assign dest_data     = dest_data_q;
  assign sup_threshold = sup_q;
  assign inf_threshold = inf_q;

`ifdef DRAIN_COUNT_EN
  // Counts clear on the edge that enters INIT.
  logic count_clr;
  assign count_clr = (state_d == ST_INIT) && (state_q != ST_INIT);

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
    dest_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (count_clr),
      .inc     (dest_push_q[g]),
      .count   (dest_count[g*CNT_W +: CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_fifo_drain_demux.sv
// Bench for fifo_drain_demux: a queue-based FIFO feeds the DUT, every popped
// word is expected back on the destinations in pop order, on the destination
// named by its top bits, and never into a destination flagged almost_full.
module tb_fifo_drain_demux;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L;
  logic       init;
  logic [2:0] sup_th_in, inf_th_in;
  logic [9:0] fifo_data = '0;
  logic       fifo_empty = 1'b1;
  logic [3:0] dest_almost_full;
  wire        fifo_pop;
  wire  [2:0] sup_threshold, inf_threshold;
  wire  [3:0] dest_push;
  wire  [9:0] dest_data;
  wire  [3:0] state;
  wire        idle;
`ifdef DRAIN_COUNT_EN
  wire [31:0] dest_count;
`endif

  fifo_drain_demux dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .init             (init),
    .sup_th_in        (sup_th_in),
    .inf_th_in        (inf_th_in),
    .fifo_data        (fifo_data),
    .fifo_empty       (fifo_empty),
    .dest_almost_full (dest_almost_full),
    .fifo_pop         (fifo_pop),
    .sup_threshold    (sup_threshold),
    .inf_threshold    (inf_threshold),
    .dest_push        (dest_push),
    .dest_data        (dest_data),
    .state            (state),
    .idle             (idle)
`ifdef DRAIN_COUNT_EN
    ,
    .dest_count       (dest_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] fq[$];      // words waiting in the upstream FIFO
  logic [9:0] exp_q[$];   // words popped but not yet delivered, in order
  int         cyc = 0;
  logic       pop_n = 1'b0;
  logic [3:0] af_prev = '0;
  int         popped = 0;
  int         delivered = 0;
  int         cnt_model[4];

  int         pop_log[$];
  int         push_cyc_log[$];
  logic [3:0] push_vec_log[$];
  logic [9:0] push_dat_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Upstream FIFO model: a pop seen in a cycle delivers data_out just after the
  // edge, and empty reflects the pop at the same edge.
  always begin
    @(posedge clk);
    #1;
    if (!reset_L) begin
      fq.delete();
      exp_q.delete();
    end else if (pop_n) begin
      chk("pop_nonempty", fq.size() != 0, 1);
      if (fq.size() != 0) begin
        fifo_data = fq.pop_front();
        exp_q.push_back(fifo_data);
        popped++;
      end
    end
    fifo_empty = (fq.size() == 0);
  end

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    logic [9:0] w;
    cyc++;
    pop_n = fifo_pop;
    if (!reset_L) begin
      for (int d = 0; d < 4; d++) cnt_model[d] = 0;
    end else begin
      chk("state_onehot", $onehot(state), 1);
      chk("idle_decode", idle, state == 4'b0100);
      chk("push_onehot0", $onehot0(dest_push), 1);
      if (fifo_pop) begin
        chk("pop_when_empty", fifo_empty, 0);
        pop_log.push_back(cyc);
      end
      if (dest_push != 4'b0000) begin
        push_cyc_log.push_back(cyc);
        push_vec_log.push_back(dest_push);
        push_dat_log.push_back(dest_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL push_unexpected actual=%0h/%0h required=none", dest_push, dest_data);
        end else begin
          w = exp_q.pop_front();
          chk("push_data", dest_data, w);
          chk("push_dest", dest_push, 4'b0001 << w[9:8]);
          chk("push_into_full", dest_push & af_prev, 0);
          delivered++;
          if (cnt_model[w[9:8]] < 255) cnt_model[w[9:8]]++;
        end
      end
    end
    af_prev = dest_almost_full;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    push_cyc_log.delete();
    push_vec_log.delete();
    push_dat_log.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(fq.size() == 0 && exp_q.size() == 0 &&
                           fifo_empty && state == 4'b0100)) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ev[4];
    logic [9:0] ed[4];
    int start_c, drop_c, npops, p0, d0, loaded, init_cnt;

    reset_L = 1'b0; init = 1'b0; sup_th_in = 3'd0; inf_th_in = 3'd0;
    dest_almost_full = 4'b0000;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", state, 4'b0001);
    chk("rst_sup", sup_threshold, 3'b110);
    chk("rst_inf", inf_threshold, 3'b001);
    chk("rst_push", dest_push, 0);
    chk("rst_pop", fifo_pop, 0);
    reset_L = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_to_idle", state, 4'b0100);

    // Threshold load through INIT.
    tick();
    init = 1'b1; sup_th_in = 3'd5; inf_th_in = 3'd2;
    tick();
    @(negedge clk);
    chk("init_state", state, 4'b0010);
    chk("init_sup_not_yet", sup_threshold, 3'b110);
    tick();
    init = 1'b0;
    @(negedge clk);
    chk("init_sup", sup_threshold, 3'd5);
    chk("init_inf", inf_threshold, 3'd2);
    tick();
    @(negedge clk);
    chk("init_exit", state, 4'b0100);

    // Four words to four destinations, unstalled.
    tick();
    clear_logs();
    fq.push_back(10'h001); fq.push_back(10'h102);
    fq.push_back(10'h203); fq.push_back(10'h304);
    wait_drain("seq_drain", 60);
    ev[0] = 4'b0001; ev[1] = 4'b0010; ev[2] = 4'b0100; ev[3] = 4'b1000;
    ed[0] = 10'h001; ed[1] = 10'h102; ed[2] = 10'h203; ed[3] = 10'h304;
    chk("seq_npops", pop_log.size(), 4);
    chk("seq_npush", push_vec_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (push_vec_log.size() > i && pop_log.size() > 0) begin
        chk("seq_vec", push_vec_log[i], ev[i]);
        chk("seq_data", push_dat_log[i], ed[i]);
        chk("seq_cycle", push_cyc_log[i], pop_log[0] + 2 + i);
      end
    end
    chk("empty_state", state, 4'b0100);
    chk("empty_idle", idle, 1);
    chk("empty_pop", fifo_pop, 0);

    // Stall on destination 1.
    tick();
    clear_logs();
    dest_almost_full = 4'b0010;
    fq.push_back(10'h105); fq.push_back(10'h006);
    start_c = cyc + 1;
    repeat (5) tick();
    dest_almost_full = 4'b0000;
    drop_c = cyc + 1;
    wait_drain("stall_drain", 60);
    npops = 0;
    foreach (pop_log[i]) if (pop_log[i] >= start_c && pop_log[i] < drop_c) npops++;
    chk("stall_pops_held", npops, 1);
    chk("stall_npush", push_vec_log.size(), 2);
    if (push_vec_log.size() >= 2) begin
      chk("stall_vec0", push_vec_log[0], 4'b0010);
      chk("stall_data0", push_dat_log[0], 10'h105);
      chk("stall_cyc0", push_cyc_log[0], drop_c + 1);
      chk("stall_vec1", push_vec_log[1], 4'b0001);
      chk("stall_data1", push_dat_log[1], 10'h006);
      chk("stall_order", push_cyc_log[1] > push_cyc_log[0], 1);
    end

    // Randomized traffic with almost_full and init pulses.
    p0 = popped; d0 = delivered; loaded = 0; init_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if ($urandom_range(0, 2) == 0 && fq.size() < 16) begin
        fq.push_back(10'($urandom_range(0, 1023)));
        loaded++;
      end
      for (int d = 0; d < 4; d++) dest_almost_full[d] = ($urandom_range(0, 3) == 0);
      if (init_cnt > 0) init_cnt--;
      else if ($urandom_range(0, 99) == 0) init_cnt = $urandom_range(1, 3);
      init = (init_cnt > 0);
    end
    tick();
    init = 1'b0;
    dest_almost_full = 4'b0000;
    wait_drain("rand_drain", 500);
    chk("rand_all_popped", popped - p0, loaded);
    chk("rand_all_delivered", delivered - d0, loaded);
    chk("rand_sup_kept", sup_threshold, 3'd5);
    chk("rand_inf_kept", inf_threshold, 3'd2);

    // Asynchronous reset in the middle of ACTIVE.
    tick();
    for (int i = 0; i < 8; i++) fq.push_back(10'h0A5 + 10'(i * 'h101));
    repeat (5) tick();
    chk("pre_rst_active", state, 4'b1000);
    reset_L = 1'b0;
    #1;
    chk("mid_rst_state", state, 4'b0001);
    chk("mid_rst_sup", sup_threshold, 3'b110);
    chk("mid_rst_inf", inf_threshold, 3'b001);
    chk("mid_rst_push", dest_push, 0);
    chk("mid_rst_data", dest_data, 0);
    chk("mid_rst_pop", fifo_pop, 0);
    chk("mid_rst_idle", idle, 0);
    tick();
    tick();
    reset_L = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_idle", state, 4'b0100);

`ifdef DRAIN_COUNT_EN
    tick();
    for (int i = 0; i < 300; i++) fq.push_back(10'h200 | 10'(i & 8'hFF));
    wait_drain("cnt_drain", 1000);
    tick();
    tick();
    @(negedge clk);
    chk("cnt_sat_dest2", dest_count[23:16], 8'hFF);
    for (int d = 0; d < 4; d++) chk("cnt_model", dest_count[d*8 +: 8], cnt_model[d]);
    tick();
    init = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("cnt_init_state", state, 4'b0010);
    chk("cnt_init_clear", dest_count[23:16], 8'h00);
    tick();
    init = 1'b0;
    tick();
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_demux.md
# fifo_drain_demux

Downstream consumer of the 10-bit FIFO. Pops words whenever the FIFO is non-empty, routes each word by its two MSBs (`data[9:8]`) to one of four destination FIFOs, and stalls per destination on that destination's `almost_full`. Also owns the FIFO's configuration: it latches the upper/lower thresholds during INIT and drives them to the FIFO. It reports its own RESET/INIT/IDLE/ACTIVE state.

## Interface
- `DATA_W`, 10, word width; the destination selector is bits `[DATA_W-1:DATA_W-2]`.
- `TH_W`, 3, threshold width.
- `SUP_DEF`, 3'b110, reset value of `sup_threshold`.
- `INF_DEF`, 3'b001, reset value of `inf_threshold`.
- `clk`  in  1  single clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  request for INIT (threshold load).
- `sup_th_in`  in  TH_W  upper threshold to latch in INIT.
- `inf_th_in`  in  TH_W  lower threshold to latch in INIT.
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid the cycle after `fifo_pop`.
- `fifo_empty`  in  1  FIFO empty flag.
- `dest_almost_full`  in  4  almost_full of destinations 0..3.
- `fifo_pop`  out  1  pop to FIFO (combinational).
- `sup_threshold`, `inf_threshold`  out  TH_W  to FIFO threshold inputs.
- `dest_push`  out  4  one-hot registered push.
- `dest_data`  out  DATA_W  registered word for the destinations.
- `state`  out  4  one-hot state.
- `idle`  out  1  high when `state` is IDLE.

## Operation
- States: RESET=4'b0001, INIT=4'b0010, IDLE=4'b0100, ACTIVE=4'b1000.
- Transitions:
  - RESET→INIT when `init`=1, else RESET→IDLE.
  - INIT: latches `sup_th_in`/`inf_th_in` every cycle. INIT→IDLE when `init`=0.
  - IDLE→INIT when `init`=1. Otherwise IDLE→ACTIVE when `fifo_empty`=0.
  - ACTIVE→IDLE when `fifo_empty`=1, `pending`=0 and `hold_valid`=0.
  - `init` in ACTIVE stops new pops. INIT is entered once `pending` and `hold_valid` are both 0. No word is dropped.
- `fifo_pop` = ACTIVE & !init & !fifo_empty & !hold_valid & !(pending & dest_almost_full[fifo_data[9:8]]).
- `pending` is a register. It is set the cycle after `fifo_pop`, meaning `fifo_data` is valid this cycle.
- When `pending` and the selected destination is not almost_full:
  - next edge sets `dest_push[sel]`=1 and `dest_data`=`fifo_data`.
- When `pending` and the selected destination is almost_full:
  - word goes to the hold register; `hold_valid`=1.
- When `hold_valid`: the hold word is pushed on the first cycle its destination's almost_full is 0, then `hold_valid` clears.
- `dest_push` is high for exactly one cycle per word. Otherwise it is 4'b0000; `dest_data` keeps its last value.
- Word order is preserved across all destinations: a held word blocks all later words.
- Reset (any time, asynchronous):
  - `state`=RESET.
  - `pending`, `hold_valid`, `dest_push`, `fifo_pop` = 0.
  - `dest_data`=0.
  - thresholds = `SUP_DEF`/`INF_DEF`.
  - In-flight words are discarded.

## Timing
- Pop in cycle N → `dest_push`/`dest_data` visible in cycle N+2 when unstalled: 2-cycle latency.
- Back-to-back pops sustain 1 word/cycle while no destination is almost_full.
- A stall costs the cycles almost_full is high, plus 1 cycle (push from the hold register).
- Threshold outputs change on the edge after `init` is sampled in INIT.
- `fifo_empty` must reflect a pop at the same edge; a 1-entry FIFO is popped exactly once.

## Configuration
- `DRAIN_COUNT_EN` defined:
  - adds output `dest_count` (4×8 bits, packed, destination 0 in LSBs).
  - Each count increments on its `dest_push` and saturates at 8'hFF.
  - Counts clear on reset and on entry to INIT.
- Undefined: no port, no counters; behaviour is otherwise identical.

## Structure
- Shared package/include `fifo_pkg`: state encodings, `DATA_W`, `TH_W`, selector field position, threshold defaults.
- Sub-module `dest_counter`: 8-bit saturating counter with clear. Instantiated 4× only under `DRAIN_COUNT_EN`.

## Test plan
- Reset with `reset_L`=0 mid-ACTIVE → all outputs at reset values immediately; `state`=4'b0001, thresholds 3'b110/3'b001.
- `init`=1, `sup_th_in`=5, `inf_th_in`=2 for 2 cycles, then 0 → `sup_threshold`=5, `inf_threshold`=2; `state` goes INIT→IDLE.
- FIFO loaded with 10'h001, 10'h102, 10'h203, 10'h304; no almost_full → `dest_push` = 0001, 0010, 0100, 1000 on consecutive cycles, the first 2 cycles after the first pop.
- `dest_almost_full[1]`=1 for 5 cycles while 10'h105 then 10'h006 are queued → 10'h105 pushed to dest 1 one cycle after almost_full drops, 10'h006 after it; no pops while held.
- FIFO emptied with nothing in flight → `state` returns to 4'b0100, `idle`=1, `fifo_pop`=0.
- With `DRAIN_COUNT_EN`: 300 words to dest 2 → `dest_count[23:16]`=8'hFF; entering INIT clears it to 0.
